// File: rtl/console_pkg.sv
// Shared types and constants for the text console writer: FSM states,
// ASCII control codes and cursor field widths.
package console_pkg;

  localparam int COLS_W = 6;
  localparam int ROWS_W = 5;

  localparam logic [7:0] ASC_LF       = 8'h0A;
  localparam logic [7:0] ASC_CR       = 8'h0D;
  localparam logic [7:0] ASC_BS       = 8'h08;
  localparam logic [7:0] ASC_SP       = 8'h20;
  localparam logic [7:0] ASC_PRINT_LO = 8'h20;
  localparam logic [7:0] ASC_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_CLEAR
  } state_t;

  // Row index advance with explicit wrap at the last visible row.
  function automatic logic [ROWS_W-1:0] row_inc(input logic [ROWS_W-1:0] row,
                                                input int rows);
    return (row == ROWS_W'(rows - 1)) ? '0 : row + 1'b1;
  endfunction

endpackage

// File: rtl/text_console_writer.sv
// Character sink that writes ASCII into a circular-row text buffer at a
// hardware cursor, handling newline, backspace, wrap and scroll.
module text_console_writer
  import console_pkg::*;
#(
  parameter int         COLS  = 64,
  parameter int         ROWS  = 30,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [7:0]               in_ascii,
  output logic                     in_ready,
  output logic                     mem_we,
  output logic [ROWS_W+COLS_W-1:0] mem_addr,
  output logic [7:0]               mem_data,
  output logic [ROWS_W-1:0]        cursor_row,
  output logic [COLS_W-1:0]        cursor_col,
  output logic [ROWS_W-1:0]        top_row,
  output logic                     busy
);

  localparam int ADDR_W = ROWS_W + COLS_W;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_is_bs;
  logic                r_in_ready;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [7:0]          r_mem_data;
  logic [ROWS_W-1:0]   r_cursor_row;
  logic [COLS_W-1:0]   r_cursor_col;
  logic [ROWS_W-1:0]   r_top_row;
  logic                r_busy;

  logic                w_accept;
  logic                w_printable;
  logic                w_is_nl_code;
  logic                w_col_last;
  logic                w_newline;
  logic [ROWS_W-1:0]   w_next_row;

  assign w_accept     = in_valid & r_in_ready & (r_state == ST_IDLE);
  assign w_printable  = (in_ascii >= ASC_PRINT_LO) && (in_ascii <= ASC_PRINT_HI);
  assign w_is_nl_code = (in_ascii == ASC_LF) || (in_ascii == ASC_CR);
  assign w_col_last   = (r_cursor_col == COLS_W'(COLS - 1));
  assign w_next_row   = row_inc(r_cursor_row, ROWS);

  // Newline is entered either from an accepted LF/CR or from a printable
  // character that was just written into the last column.
  assign w_newline = (w_accept && w_is_nl_code) ||
                     ((r_state == ST_WRITE) && !r_is_bs && w_col_last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_INIT;
      r_cnt        <= '0;
      r_is_bs      <= 1'b0;
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= BLANK;
      r_cursor_row <= '0;
      r_cursor_col <= '0;
      r_top_row    <= '0;
      r_busy       <= 1'b1;
    end else if (w_newline) begin
      r_cursor_row <= w_next_row;
      r_cursor_col <= '0;
      if (w_next_row == r_top_row) begin
        r_top_row <= row_inc(r_top_row, ROWS);
      end
      r_state    <= ST_CLEAR;
      r_cnt      <= '0;
      r_mem_we   <= 1'b1;
      r_mem_addr <= {w_next_row, {COLS_W{1'b0}}};
      r_mem_data <= BLANK;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          // Linear counter doubles as {row,col} because COLS is a power of two.
          if (r_cnt == ADDR_W'(ROWS * COLS)) begin
            r_mem_we   <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_mem_we   <= 1'b1;
            r_mem_addr <= r_cnt;
            r_mem_data <= BLANK;
            r_cnt      <= r_cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (w_accept) begin
            if (w_printable) begin
              r_state    <= ST_WRITE;
              r_mem_we   <= 1'b1;
              r_mem_addr <= {r_cursor_row, r_cursor_col};
              r_mem_data <= in_ascii;
              r_in_ready <= 1'b0;
              r_is_bs    <= 1'b0;
            end else if ((in_ascii == ASC_BS) && (r_cursor_col != '0)) begin
              r_state    <= ST_WRITE;
              r_mem_we   <= 1'b1;
              r_mem_addr <= {r_cursor_row, r_cursor_col - 1'b1};
              r_mem_data <= BLANK;
              r_in_ready <= 1'b0;
              r_is_bs    <= 1'b1;
            end
          end
        end
        ST_WRITE: begin
          r_mem_we   <= 1'b0;
          r_in_ready <= 1'b1;
          r_state    <= ST_IDLE;
          if (r_is_bs) begin
            r_cursor_col <= r_cursor_col - 1'b1;
          end else begin
            r_cursor_col <= r_cursor_col + 1'b1;
          end
        end
        ST_CLEAR: begin
          if (r_cnt[COLS_W-1:0] == COLS_W'(COLS - 1)) begin
            r_mem_we   <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt      <= r_cnt + 1'b1;
            r_mem_addr <= {r_cursor_row, r_cnt[COLS_W-1:0] + 1'b1};
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign cursor_row = r_cursor_row;
  assign cursor_col = r_cursor_col;
  assign top_row    = r_top_row;
  assign busy       = r_busy;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: init fill, plain writes, wrap,
// newline/scroll, backspace, ignored codes and asynchronous abort.
module tb_text_console_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ascii = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [10:0] mem_addr;
  logic [7:0]  mem_data;
  logic [4:0]  cursor_row;
  logic [5:0]  cursor_col;
  logic [4:0]  top_row;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [10:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  int          lat;

  text_console_writer dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ascii   (in_ascii),
    .in_ready   (in_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col),
    .top_row    (top_row),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pulse reset, then watch the whole fill pass until the block is ready.
  task automatic do_init(input string tag);
    int n = 0;
    int bad = 0;
    int cyc = 0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    while (!in_ready && cyc < 2500) begin
      @(negedge clk);
      cyc++;
      if (mem_we) begin
        if (mem_addr !== n[10:0] || mem_data !== 8'h20) bad++;
        n++;
      end
    end
    check({tag, "_init_writes"}, n, 1920);
    check({tag, "_init_bad"}, bad, 0);
    check({tag, "_init_ready"}, in_ready, 1);
    check({tag, "_init_busy"}, busy, 0);
    check({tag, "_init_cursor"}, {cursor_row, cursor_col, top_row}, 0);
    $display("init %s: %0d writes in %0d cycles", tag, n, cyc);
  endtask

  // Offer one character, then record every write until in_ready returns.
  task automatic send(input logic [7:0] c);
    int w = 0;
    wr_addr.delete();
    wr_data.delete();
    lat = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_ascii = c;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      lat++;
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_data);
      end
    end while (!in_ready && lat < 200);
  endtask

  // Writes must be contiguous from base; first carries d0, the rest BLANK.
  task automatic expect_writes(input string tag, input int n, input logic [10:0] base,
                               input logic [7:0] d0, input int exp_lat);
    int bad = 0;
    logic [10:0] a;
    logic [7:0]  d;
    check({tag, "_nwrites"}, wr_addr.size(), n);
    for (int i = 0; i < wr_addr.size(); i++) begin
      a = base + 11'(i);
      d = (i == 0) ? d0 : 8'h20;
      if (wr_addr[i] !== a || wr_data[i] !== d) bad++;
    end
    check({tag, "_wr_bad"}, bad, 0);
    check({tag, "_latency"}, lat, exp_lat);
    $display("txn %s: %0d writes, latency %0d, cursor (%0d,%0d) top %0d",
             tag, wr_addr.size(), lat, cursor_row, cursor_col, top_row);
  endtask

  initial begin
    int bad;

    @(negedge clk);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_data", mem_data, 8'h20);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_cursor", {cursor_row, cursor_col, top_row}, 0);
    do_init("por");

    send(8'h41);
    expect_writes("char_A", 1, 11'h000, 8'h41, 2);
    send(8'h42);
    expect_writes("char_B", 1, 11'h001, 8'h42, 2);
    check("ab_col", cursor_col, 2);
    check("ab_row", cursor_row, 0);

    do_init("wrap");
    bad = 0;
    for (int i = 0; i < 63; i++) begin
      send(8'h30);
      if (wr_addr.size() != 1 || wr_addr[0] !== 11'(i) || lat != 2) bad++;
    end
    check("fill_row_bad", bad, 0);
    send(8'h30);
    expect_writes("wrap_char", 65, 11'h03F, 8'h30, 66);
    check("wrap_cursor", {cursor_row, cursor_col}, {5'd1, 6'd0});
    check("wrap_top", top_row, 0);

    do_init("nl");
    send(8'h0A);
    expect_writes("lf_first", 64, 11'h040, 8'h20, 65);
    for (int i = 0; i < 28; i++) send(8'h0A);
    check("lf29_row", cursor_row, 29);
    check("lf29_top", top_row, 0);
    send(8'h0D);
    expect_writes("cr_scroll", 64, 11'h000, 8'h20, 65);
    check("scroll_cursor", {cursor_row, cursor_col}, 0);
    check("scroll_top", top_row, 1);

    do_init("bs");
    send(8'h58);
    send(8'h59);
    send(8'h08);
    expect_writes("bs_1", 1, 11'h001, 8'h20, 2);
    check("bs1_col", cursor_col, 1);
    send(8'h08);
    expect_writes("bs_2", 1, 11'h000, 8'h20, 2);
    check("bs2_col", cursor_col, 0);
    send(8'h08);
    expect_writes("bs_3", 0, 11'h000, 8'h00, 1);
    check("bs3_col", cursor_col, 0);

    send(8'h0A);
    check("pre_abort_row", cursor_row, 1);
    while (!in_ready) @(negedge clk);
    in_valid = 1'b1;
    in_ascii = 8'h0A;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("mid_clear_busy", busy, 1);
    check("mid_clear_we", mem_we, 1);
    #2 rst = 1'b0;
    #1;
    check("abort_we", mem_we, 0);
    check("abort_ready", in_ready, 0);
    check("abort_busy", busy, 1);
    check("abort_addr", mem_addr, 0);
    check("abort_data", mem_data, 8'h20);
    check("abort_cursor", {cursor_row, cursor_col, top_row}, 0);
    $display("abort: reset asserted mid-clear");
    do_init("abort");
    send(8'h07);
    expect_writes("bel", 0, 11'h000, 8'h00, 1);
    check("bel_col", cursor_col, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
